// File: rtl/beat_scheduler_if.sv
// Launch/completion handshake between the beat scheduler and the ball engine.
// master = scheduler side, slave = ball/render engine side.
interface beat_scheduler_if;
  logic        SPAWN_VALID;
  logic        SPAWN_READY;
  logic [2:0]  SPAWN_LANE;
  logic [11:0] SPAWN_COLOR;
  logic        BALL_DONE;
  logic        BALL_HIT;

  modport master (
    output SPAWN_VALID,
    output SPAWN_LANE,
    output SPAWN_COLOR,
    input  SPAWN_READY,
    input  BALL_DONE,
    input  BALL_HIT
  );

  modport slave (
    input  SPAWN_VALID,
    input  SPAWN_LANE,
    input  SPAWN_COLOR,
    output SPAWN_READY,
    output BALL_DONE,
    output BALL_HIT
  );
endinterface

// File: rtl/beat_scheduler.sv
// Rhythm-game session sequencer: tempo latch, beat-spaced ball launches, hit tally.
// Optional BALL_TIMEOUT_EN: a ball unreported after 2*BEAT_LEN ticks counts as a miss.
module beat_scheduler #(
  parameter int unsigned TICK_DIV = 100,
  parameter int unsigned BEAT_120 = 1_000_000,
  parameter int unsigned BEAT_100 = 1_200_000,
  parameter int unsigned BEAT_160 = 750_000,
  parameter int unsigned ROUNDS   = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic [3:0]            CHOICE,
  input  logic [31:0]           MUSIC_DATA,
  output logic [20:0]           BEAT_LEN,
  output logic [7:0]            ROUND,
  output logic [7:0]            HITS,
  output logic                  BUSY,
  output logic                  FINISH,
  beat_scheduler_if.master      spawn
);

  localparam int unsigned PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SPAWN,
    S_WAIT,
    S_GAP,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [21:0]   cnt_q, cnt_d;
  logic [20:0]   beat_q, beat_d;
  logic [7:0]    round_q, round_d;
  logic [7:0]    hits_q, hits_d;
  logic          valid_q, valid_d;
  logic [2:0]    lane_q, lane_d;
  logic [11:0]   color_q, color_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;

  logic          tick;
  logic [21:0]   cnt_inc;
  logic [20:0]   beat_sel;
  logic [31:0]   rem;

  always_comb begin
    tick    = (pre_q == PRE_MAX);
    pre_d   = tick ? '0 : pre_q + 1'b1;
    cnt_inc = (tick && (cnt_q != '1))
              ? cnt_q + 22'd1 : cnt_q;
    rem     = MUSIC_DATA % 32'd60;

    unique case (CHOICE)
      4'd2:    beat_sel = 21'(BEAT_100);
      4'd3:    beat_sel = 21'(BEAT_160);
      default: beat_sel = 21'(BEAT_120);
    endcase

    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    round_d = round_q;
    hits_d  = hits_q;
    valid_d = valid_q;
    lane_d  = lane_q;
    color_d = color_q;
    busy_d  = busy_q;
    fin_d   = fin_q;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          beat_d  = beat_sel;
          round_d = '0;
          hits_d  = '0;
          fin_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (rem < 32'd10) begin
          lane_d  = 3'd1;
          color_d = 12'hF00;
        end else if (rem < 32'd20) begin
          lane_d  = 3'd2;
          color_d = 12'hFA0;
        end else if (rem < 32'd30) begin
          lane_d  = 3'd3;
          color_d = 12'hFF0;
        end else if (rem < 32'd40) begin
          lane_d  = 3'd3;
          color_d = 12'h0F0;
        end else if (rem < 32'd50) begin
          lane_d  = 3'd4;
          color_d = 12'h00F;
        end else begin
          lane_d  = 3'd5;
          color_d = 12'hA2F;
        end
        valid_d = 1'b1;
        state_d = S_SPAWN;
      end
      S_SPAWN: begin
        // done pulses here belong to no accepted ball
        if (spawn.SPAWN_READY) begin
          valid_d = 1'b0;
          round_d = round_q + 8'd1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (spawn.BALL_DONE) begin
          hits_d  = hits_q + {7'd0, spawn.BALL_HIT};
          state_d = S_GAP;
        end
`ifdef BALL_TIMEOUT_EN
        else if (cnt_q >= {beat_q, 1'b0}) begin
          state_d = S_GAP;
        end
`endif
      end
      S_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q >= {1'b0, beat_q}) begin
          if (round_q == 8'(ROUNDS)) begin
            fin_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      round_q <= '0;
      hits_q  <= '0;
      valid_q <= 1'b0;
      lane_q  <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      round_q <= round_d;
      hits_q  <= hits_d;
      valid_q <= valid_d;
      lane_q  <= lane_d;
      color_q <= color_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  assign spawn.SPAWN_VALID = valid_q;
  assign spawn.SPAWN_LANE  = lane_q;
  assign spawn.SPAWN_COLOR = color_q;
  assign BEAT_LEN          = beat_q;
  assign ROUND             = round_q;
  assign HITS              = hits_q;
  assign BUSY              = busy_q;
  assign FINISH            = fin_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// Directed bench for beat_scheduler with shortened timing.
// Launch spacing, decode, stall, fast gap, reset and timeout cases.
module tb_beat_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        START = 1'b0;
  logic [3:0]  CHOICE = 4'd0;
  logic [31:0] MUSIC_DATA = 32'd0;
  logic [20:0] BEAT_LEN;
  logic [7:0]  ROUND;
  logic [7:0]  HITS;
  logic        BUSY;
  logic        FINISH;

  beat_scheduler_if bif();

  beat_scheduler #(
    .TICK_DIV (2),
    .BEAT_120 (20),
    .BEAT_100 (24),
    .BEAT_160 (15),
    .ROUNDS   (3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .START      (START),
    .CHOICE     (CHOICE),
    .MUSIC_DATA (MUSIC_DATA),
    .BEAT_LEN   (BEAT_LEN),
    .ROUND      (ROUND),
    .HITS       (HITS),
    .BUSY       (BUSY),
    .FINISH     (FINISH),
    .spawn      (bif.master)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int maxc);
    int c = 0;
    while (bif.SPAWN_VALID !== 1'b1 && c < maxc) begin
      @(negedge CLK);
      c++;
    end
    chk("valid_seen", {31'd0, bif.SPAWN_VALID}, 32'd1);
  endtask

  task automatic start_session(input logic [3:0] ch);
    @(negedge CLK);
    CHOICE = ch;
    START  = 1'b1;
    @(negedge CLK);
    START  = 1'b0;
  endtask

  task automatic pulse_done(input logic hit);
    bif.BALL_DONE = 1'b1;
    bif.BALL_HIT  = hit;
    @(negedge CLK);
    bif.BALL_DONE = 1'b0;
    bif.BALL_HIT  = 1'b0;
  endtask

  task automatic chk_cleared();
    chk("rst_valid", {31'd0, bif.SPAWN_VALID}, 32'd0);
    chk("rst_lane", {29'd0, bif.SPAWN_LANE}, 32'd0);
    chk("rst_color", {20'd0, bif.SPAWN_COLOR}, 32'd0);
    chk("rst_beat", {11'd0, BEAT_LEN}, 32'd0);
    chk("rst_round", {24'd0, ROUND}, 32'd0);
    chk("rst_hits", {24'd0, HITS}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_finish", {31'd0, FINISH}, 32'd0);
  endtask

  int mus[3]   = '{9, 10, 59};
  int lanes[3] = '{1, 2, 5};
  int cols[3]  = '{32'hF00, 32'hFA0, 32'hA2F};
  int rise[3];
  int d;

  initial begin
    bif.SPAWN_READY = 1'b0;
    bif.BALL_DONE   = 1'b0;
    bif.BALL_HIT    = 1'b0;

    repeat (3) @(negedge CLK);
    chk_cleared();
    RST = 1'b1;

    // three rounds, ready held high, hits 5 ticks in
    bif.SPAWN_READY = 1'b1;
    MUSIC_DATA = 32'd9;
    start_session(4'd1);
    chk("busy_arm", {31'd0, BUSY}, 32'd1);
    chk("beat_120", {11'd0, BEAT_LEN}, 32'd20);
    for (int i = 0; i < 3; i++) begin
      MUSIC_DATA = mus[i];
      wait_valid(60);
      rise[i] = cyc;
      chk("lane", {29'd0, bif.SPAWN_LANE}, lanes[i]);
      chk("color", {20'd0, bif.SPAWN_COLOR}, cols[i]);
      @(negedge CLK);
      chk("valid_drop", {31'd0, bif.SPAWN_VALID}, 32'd0);
      chk("round", {24'd0, ROUND}, i + 1);
      repeat (9) @(negedge CLK);
      pulse_done(1'b1);
      chk("hits", {24'd0, HITS}, i + 1);
    end
    for (int i = 0; i < 2; i++) begin
      d = rise[i+1] - rise[i];
      chk("spacing", {31'd0, (d >= 42 && d <= 43)}, 32'd1);
    end
    for (int c = 0; c < 80 && FINISH !== 1'b1; c++)
      @(negedge CLK);
    chk("finish", {31'd0, FINISH}, 32'd1);
    chk("busy_fin", {31'd0, BUSY}, 32'd0);
    chk("round_fin", {24'd0, ROUND}, 32'd3);
    chk("hits_fin", {24'd0, HITS}, 32'd3);

    // decode 35, stall 7 cycles with data changing
    bif.SPAWN_READY = 1'b0;
    MUSIC_DATA = 32'd35;
    start_session(4'd2);
    chk("finish_clr", {31'd0, FINISH}, 32'd0);
    chk("beat_100", {11'd0, BEAT_LEN}, 32'd24);
    wait_valid(10);
    chk("lane35", {29'd0, bif.SPAWN_LANE}, 32'd3);
    chk("color35", {20'd0, bif.SPAWN_COLOR}, 32'h0F0);
    MUSIC_DATA = 32'd0;
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      chk("hold_valid", {31'd0, bif.SPAWN_VALID}, 32'd1);
      chk("hold_lane", {29'd0, bif.SPAWN_LANE}, 32'd3);
      chk("hold_color", {20'd0, bif.SPAWN_COLOR}, 32'h0F0);
      chk("hold_round", {24'd0, ROUND}, 32'd0);
    end
    // done on the handshake cycle must be dropped
    bif.SPAWN_READY = 1'b1;
    bif.BALL_DONE   = 1'b1;
    bif.BALL_HIT    = 1'b1;
    @(negedge CLK);
    bif.BALL_DONE   = 1'b0;
    bif.BALL_HIT    = 1'b0;
    chk("hs_valid", {31'd0, bif.SPAWN_VALID}, 32'd0);
    chk("hs_round", {24'd0, ROUND}, 32'd1);
    repeat (60) @(negedge CLK);
    chk("hs_hits", {24'd0, HITS}, 32'd0);
    chk("hs_busy", {31'd0, BUSY}, 32'd1);

    // late miss: GAP one cycle, ARM one cycle
    pulse_done(1'b0);
    chk("late_gap", {31'd0, bif.SPAWN_VALID}, 32'd0);
    chk("late_hits", {24'd0, HITS}, 32'd0);
    @(negedge CLK);
    chk("late_arm", {31'd0, bif.SPAWN_VALID}, 32'd0);
    @(negedge CLK);
    chk("late_spawn", {31'd0, bif.SPAWN_VALID}, 32'd1);
    chk("lane0", {29'd0, bif.SPAWN_LANE}, 32'd1);
    chk("color0", {20'd0, bif.SPAWN_COLOR}, 32'hF00);
    @(negedge CLK);
    chk("round2", {24'd0, ROUND}, 32'd2);

    // START while busy ignored, then async reset
    START = 1'b1;
    CHOICE = 4'd3;
    @(negedge CLK);
    START = 1'b0;
    chk("ign_beat", {11'd0, BEAT_LEN}, 32'd24);
    chk("ign_round", {24'd0, ROUND}, 32'd2);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk_cleared();
    @(negedge CLK);
    RST = 1'b1;

    start_session(4'd3);
    chk("beat_160", {11'd0, BEAT_LEN}, 32'd15);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    start_session(4'd7);
    chk("beat_dflt", {11'd0, BEAT_LEN}, 32'd20);

    // no completion reports at all
    bif.SPAWN_READY = 1'b1;
    repeat (400) @(negedge CLK);
    chk("nodone_hits", {24'd0, HITS}, 32'd0);
`ifdef BALL_TIMEOUT_EN
    chk("to_finish", {31'd0, FINISH}, 32'd1);
    chk("to_round", {24'd0, ROUND}, 32'd3);
    chk("to_busy", {31'd0, BUSY}, 32'd0);
`else
    chk("stuck_busy", {31'd0, BUSY}, 32'd1);
    chk("stuck_round", {24'd0, ROUND}, 32'd1);
    chk("stuck_finish", {31'd0, FINISH}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
